// File: rtl/bitstream_sched_if.sv
// Handshake bundle between the bitstream scheduler and its requesters / shared datapath.
interface bitstream_sched_if #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned LEN_W = 9
);
    localparam int unsigned ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]  req;
    logic             gen_bit;
    logic             gen_en;
    logic [LEN_W-1:0] gen_idx;
    logic [NREQ-1:0]  grant;
    logic             done;
    logic [LEN_W:0]   result;
    logic [ID_W-1:0]  result_id;

    modport master (
        output req, gen_bit,
        input  gen_en, gen_idx, grant, done, result, result_id
    );

    modport slave (
        input  req, gen_bit,
        output gen_en, gen_idx, grant, done, result, result_id
    );
endinterface

// File: rtl/bitstream_sched.sv
// Round-robin time-sharing of one bitstream datapath: each grant counts the ones over a 2**LEN_W window.
// Optional macro BSCHED_ABORT_EN: the owner dropping its request mid-window abandons that window.
module bitstream_sched #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned LEN_W = 9
) (
    input logic                clk,
    input logic                n_rst,
    bitstream_sched_if.slave   bus
);
    localparam int unsigned ID_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CNT_W = LEN_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic              gen_en_q;
    logic [LEN_W-1:0]  gen_idx_q;
    logic [NREQ-1:0]   grant_q;
    logic              done_q;
    logic [CNT_W-1:0]  result_q;
    logic [ID_W-1:0]   result_id_q;
    logic [ID_W-1:0]   owner_q;
    logic [ID_W-1:0]   ptr_q;
    logic [CNT_W-1:0]  acc_q;

    logic [CNT_W-1:0]  acc_d;
    logic [ID_W-1:0]   ptr_d;
    logic              win_found_c;
    logic [ID_W-1:0]   win_id_c;
    logic              abort_c;
    int unsigned       scan_idx;

    // First requester at or after the round-robin pointer, wrapping at NREQ-1.
    always_comb begin
        win_found_c = 1'b0;
        win_id_c    = '0;
        scan_idx    = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            scan_idx = (32'(ptr_q) + i) % NREQ;
            if (!win_found_c && bus.req[ID_W'(scan_idx)]) begin
                win_found_c = 1'b1;
                win_id_c    = ID_W'(scan_idx);
            end
        end
    end

    assign acc_d = acc_q + CNT_W'(bus.gen_bit);
    assign ptr_d = (owner_q == ID_W'(NREQ - 1)) ? '0 : owner_q + ID_W'(1);

`ifdef BSCHED_ABORT_EN
    assign abort_c = !bus.req[owner_q];
`else
    assign abort_c = 1'b0;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            gen_en_q    <= 1'b0;
            gen_idx_q   <= '0;
            grant_q     <= '0;
            done_q      <= 1'b0;
            result_q    <= '0;
            result_id_q <= '0;
            owner_q     <= '0;
            ptr_q       <= '0;
            acc_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (win_found_c) begin
                        state_q   <= RUN;
                        gen_en_q  <= 1'b1;
                        gen_idx_q <= '0;
                        grant_q   <= NREQ'(1) << win_id_c;
                        owner_q   <= win_id_c;
                        acc_q     <= '0;
                    end
                end
                RUN: begin
                    if (abort_c) begin
                        // Abandoned window: result keeps the last completed count.
                        state_q   <= IDLE;
                        gen_en_q  <= 1'b0;
                        gen_idx_q <= '0;
                        grant_q   <= '0;
                        ptr_q     <= ptr_d;
                    end else if (gen_idx_q == '1) begin
                        state_q     <= DONE;
                        gen_en_q    <= 1'b0;
                        gen_idx_q   <= '0;
                        grant_q     <= '0;
                        done_q      <= 1'b1;
                        acc_q       <= acc_d;
                        result_q    <= acc_d;
                        result_id_q <= owner_q;
                    end else begin
                        gen_idx_q <= gen_idx_q + LEN_W'(1);
                        acc_q     <= acc_d;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    ptr_q   <= ptr_d;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.gen_en    = gen_en_q;
    assign bus.gen_idx   = gen_idx_q;
    assign bus.grant     = grant_q;
    assign bus.done      = done_q;
    assign bus.result    = result_q;
    assign bus.result_id = result_id_q;
endmodule

// File: tb/tb_bitstream_sched.sv
// Self-checking bench for bitstream_sched: round-robin model plus ones-count of a stored bit pattern.
module tb_bitstream_sched;
    localparam int unsigned NREQ  = 4;
    localparam int unsigned LEN_W = 9;
    localparam int         WIN    = 512;

    logic       clk   = 1'b0;
    logic       n_rst = 1'b0;
    logic [3:0] req_r = 4'b0000;
    logic       pat [WIN];

    int total    = 0;
    int bad      = 0;
    int rr_start = 0;
    int last_res = 0;
    int last_id  = 0;

    bitstream_sched_if #(.NREQ(NREQ), .LEN_W(LEN_W)) bus ();

    assign bus.req     = req_r;
    assign bus.gen_bit = pat[bus.gen_idx];

    bitstream_sched #(.NREQ(NREQ), .LEN_W(LEN_W)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic int pick(input logic [3:0] r, input int s);
        for (int i = 0; i < 4; i++) begin
            int k;
            k = (s + i) % 4;
            if (((r >> k) & 4'd1) != 4'd0) return k;
        end
        return -1;
    endfunction

    function automatic int pat_sum();
        int s;
        s = 0;
        for (int i = 0; i < WIN; i++) s += int'(pat[i]);
        return s;
    endfunction

    task automatic fill_pat(input int mode);
        for (int i = 0; i < WIN; i++) begin
            if (mode == 0)      pat[i] = 1'b1;
            else if (mode == 1) pat[i] = 1'(i % 2);
            else                pat[i] = 1'($urandom_range(0, 1));
        end
    endtask

    // Observes one window starting from the IDLE cycle in which req is presented; lat=0 on timeout.
    task automatic observe_window(output int lat, output logic [3:0] g0, output bit g_stable,
                                  output bit idx_ok, output bit done_clean,
                                  output logic [9:0] res, output logic [1:0] rid);
        lat = 0; g0 = '0; g_stable = 1'b1; idx_ok = 1'b1; done_clean = 1'b0; res = '0; rid = '0;
        for (int n = 1; n <= 700; n++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                lat        = n;
                res        = bus.result;
                rid        = bus.result_id;
                done_clean = (bus.grant === 4'b0000) && (bus.gen_en === 1'b0);
                break;
            end
            if (n == 1) g0 = bus.grant;
            if (bus.grant !== g0 || bus.gen_en !== 1'b1) g_stable = 1'b0;
            if (bus.gen_idx !== 9'(n - 1)) idx_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        n_rst = 1'b0; req_r = 4'b0000; fill_pat(0);
        repeat (2) @(negedge clk);
        total++; if (bus.gen_en !== 1'b0)     begin bad++; $display("FAIL rst_gen_en: got %0b want 0", bus.gen_en); end
        total++; if (bus.gen_idx !== 9'd0)    begin bad++; $display("FAIL rst_gen_idx: got %0d want 0", bus.gen_idx); end
        total++; if (bus.grant !== 4'b0000)   begin bad++; $display("FAIL rst_grant: got %b want 0000", bus.grant); end
        total++; if (bus.done !== 1'b0)       begin bad++; $display("FAIL rst_done: got %0b want 0", bus.done); end
        total++; if (bus.result !== 10'd0)    begin bad++; $display("FAIL rst_result: got %0d want 0", bus.result); end
        total++; if (bus.result_id !== 2'd0)  begin bad++; $display("FAIL rst_result_id: got %0d want 0", bus.result_id); end
        n_rst = 1'b1; rr_start = 0; last_res = 0; last_id = 0;
        repeat (2) @(negedge clk);
        total++; if (bus.gen_en !== 1'b0 || bus.grant !== 4'b0000) begin
            bad++; $display("FAIL idle_no_req: gen_en=%0b grant=%b want 0/0000", bus.gen_en, bus.grant); end
    endtask

    task automatic test_all_ones();
        int lat; logic [3:0] g0; bit gs, iok, dc; logic [9:0] res; logic [1:0] rid;
        fill_pat(0);
        req_r = 4'b0001;
        observe_window(lat, g0, gs, iok, dc, res, rid);
        req_r = 4'b0000;
        total++; if (lat != 513)       begin bad++; $display("FAIL ones_latency: got %0d want 513", lat); end
        total++; if (g0 !== 4'b0001)   begin bad++; $display("FAIL ones_grant: got %b want 0001", g0); end
        total++; if (!gs)              begin bad++; $display("FAIL ones_grant_stable: got 0 want 1"); end
        total++; if (!iok)             begin bad++; $display("FAIL ones_gen_idx_seq: got 0 want 1"); end
        total++; if (!dc)              begin bad++; $display("FAIL ones_done_idle: got 0 want 1"); end
        total++; if (res !== 10'd512)  begin bad++; $display("FAIL ones_result: got %0d want 512", res); end
        total++; if (rid !== 2'd0)     begin bad++; $display("FAIL ones_result_id: got %0d want 0", rid); end
        rr_start = 1; last_res = 512; last_id = 0;
        @(negedge clk);
        total++; if (bus.done !== 1'b0 || bus.result !== 10'd512) begin
            bad++; $display("FAIL ones_pulse_hold: done=%0b result=%0d want 0/512", bus.done, bus.result); end
    endtask

    task automatic test_alternating();
        int lat; logic [3:0] g0; bit gs, iok, dc; logic [9:0] res; logic [1:0] rid;
        fill_pat(1);
        req_r = 4'b0010;
        observe_window(lat, g0, gs, iok, dc, res, rid);
        req_r = 4'b0000;
        total++; if (lat != 513)       begin bad++; $display("FAIL alt_latency: got %0d want 513", lat); end
        total++; if (g0 !== 4'b0010)   begin bad++; $display("FAIL alt_grant: got %b want 0010", g0); end
        total++; if (res !== 10'd256)  begin bad++; $display("FAIL alt_result: got %0d want 256", res); end
        total++; if (rid !== 2'd1)     begin bad++; $display("FAIL alt_result_id: got %0d want 1", rid); end
        rr_start = 2; last_res = 256; last_id = 1;
        @(negedge clk);
    endtask

    task automatic test_wrap();
        int lat, exp_sum; logic [3:0] g0; bit gs, iok, dc; logic [9:0] res; logic [1:0] rid;
        fill_pat(2); exp_sum = pat_sum();
        req_r = 4'b1000;
        observe_window(lat, g0, gs, iok, dc, res, rid);
        req_r = 4'b1001;
        total++; if (rid !== 2'd3 || res !== 10'(exp_sum)) begin
            bad++; $display("FAIL wrap_first: id=%0d result=%0d want 3/%0d", rid, res, exp_sum); end
        rr_start = 0;
        @(negedge clk);
        observe_window(lat, g0, gs, iok, dc, res, rid);
        req_r = 4'b0000;
        total++; if (g0 !== 4'b0001)   begin bad++; $display("FAIL wrap_grant: got %b want 0001", g0); end
        total++; if (rid !== 2'd0 || res !== 10'(exp_sum)) begin
            bad++; $display("FAIL wrap_second: id=%0d result=%0d want 0/%0d", rid, res, exp_sum); end
        rr_start = 1; last_res = exp_sum; last_id = 0;
        @(negedge clk);
    endtask

    task automatic test_random();
        int lat, exp_sum, exp_id; logic [3:0] g0, r; bit gs, iok, dc; logic [9:0] res; logic [1:0] rid;
        for (int w = 0; w < 4; w++) begin
            fill_pat(2); exp_sum = pat_sum();
            r = 4'($urandom_range(1, 15));
            exp_id = pick(r, rr_start);
            req_r = r;
            observe_window(lat, g0, gs, iok, dc, res, rid);
            req_r = 4'b0000;
            total++; if (lat != 513 || !gs || !iok || !dc) begin
                bad++; $display("FAIL rand_window%0d: lat=%0d stable=%0b idx=%0b clean=%0b want 513/1/1/1", w, lat, gs, iok, dc); end
            total++; if (g0 !== (4'b0001 << exp_id)) begin
                bad++; $display("FAIL rand_grant%0d: got %b req %b want id %0d", w, g0, r, exp_id); end
            total++; if (res !== 10'(exp_sum) || rid !== 2'(exp_id)) begin
                bad++; $display("FAIL rand_result%0d: got %0d/%0d want %0d/%0d", w, res, rid, exp_sum, exp_id); end
            rr_start = (exp_id + 1) % 4; last_res = exp_sum; last_id = exp_id;
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        int lat, exp_sum, exp_id; logic [3:0] g0; bit gs, iok, dc; logic [9:0] res; logic [1:0] rid;
        n_rst = 1'b0; req_r = 4'b0101; fill_pat(2); exp_sum = pat_sum();
        @(negedge clk);
        n_rst = 1'b1; rr_start = 0;
        for (int w = 0; w < 3; w++) begin
            exp_id = pick(4'b0101, rr_start);
            observe_window(lat, g0, gs, iok, dc, res, rid);
            if (w == 2) req_r = 4'b0000;
            total++; if (lat != 513) begin bad++; $display("FAIL b2b_latency%0d: got %0d want 513", w, lat); end
            total++; if (rid !== 2'(exp_id) || res !== 10'(exp_sum)) begin
                bad++; $display("FAIL b2b_owner%0d: got %0d/%0d want %0d/%0d", w, rid, res, exp_id, exp_sum); end
            rr_start = (exp_id + 1) % 4; last_res = exp_sum; last_id = exp_id;
            @(negedge clk);
            total++; if (bus.gen_en !== 1'b0 || bus.grant !== 4'b0000 || bus.done !== 1'b0) begin
                bad++; $display("FAIL b2b_gap%0d: gen_en=%0b grant=%b done=%0b want idle", w, bus.gen_en, bus.grant, bus.done); end
        end
    endtask

    task automatic test_reset_mid_run();
        int lat, exp_sum, dones; bit found; logic [3:0] g0; bit gs, iok, dc; logic [9:0] res; logic [1:0] rid;
        fill_pat(0);
        req_r = 4'b0100;
        found = 1'b0;
        for (int n = 0; n < 300 && !found; n++) begin
            @(negedge clk);
            if (bus.gen_en === 1'b1 && bus.gen_idx === 9'd100) found = 1'b1;
        end
        total++; if (!found) begin bad++; $display("FAIL rstrun_reach_idx100: got 0 want 1"); end
        n_rst = 1'b0;
        #1;
        total++; if (bus.gen_en !== 1'b0 || bus.gen_idx !== 9'd0 || bus.grant !== 4'b0000) begin
            bad++; $display("FAIL rstrun_async_ctl: gen_en=%0b idx=%0d grant=%b want 0", bus.gen_en, bus.gen_idx, bus.grant); end
        total++; if (bus.done !== 1'b0 || bus.result !== 10'd0 || bus.result_id !== 2'd0) begin
            bad++; $display("FAIL rstrun_async_res: done=%0b result=%0d id=%0d want 0", bus.done, bus.result, bus.result_id); end
        req_r = 4'b0000;
        @(negedge clk);
        n_rst = 1'b1; rr_start = 0; last_res = 0; last_id = 0;
        dones = 0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            if (bus.done === 1'b1) dones++;
        end
        total++; if (dones != 0) begin bad++; $display("FAIL rstrun_no_done: got %0d want 0", dones); end
        fill_pat(2); exp_sum = pat_sum();
        req_r = 4'b1010;
        observe_window(lat, g0, gs, iok, dc, res, rid);
        req_r = 4'b0000;
        total++; if (g0 !== 4'b0010 || rid !== 2'd1) begin
            bad++; $display("FAIL rstrun_lowest: grant=%b id=%0d want 0010/1", g0, rid); end
        total++; if (lat != 513 || res !== 10'(exp_sum)) begin
            bad++; $display("FAIL rstrun_window: lat=%0d result=%0d want 513/%0d", lat, res, exp_sum); end
        rr_start = 2; last_res = exp_sum; last_id = 1;
        @(negedge clk);
    endtask

    task automatic test_abort();
        int exp_id, dones, steps; bit found;
        fill_pat(0);
        exp_id = pick(4'b0001, rr_start);
        req_r = 4'b0001;
        found = 1'b0;
        for (int n = 0; n < 200 && !found; n++) begin
            @(negedge clk);
            if (bus.gen_en === 1'b1 && bus.gen_idx === 9'd50) found = 1'b1;
        end
        total++; if (!found) begin bad++; $display("FAIL abort_reach_idx50: got 0 want 1"); end
        req_r = 4'b0000;
`ifdef BSCHED_ABORT_EN
        begin
            int lat; logic [3:0] g0; bit gs, iok, dc; logic [9:0] res; logic [1:0] rid;
            @(negedge clk);
            total++; if (bus.gen_en !== 1'b0 || bus.grant !== 4'b0000 || bus.done !== 1'b0) begin
                bad++; $display("FAIL abort_idle: gen_en=%0b grant=%b done=%0b want 0", bus.gen_en, bus.grant, bus.done); end
            total++; if (bus.result !== 10'(last_res) || bus.result_id !== 2'(last_id)) begin
                bad++; $display("FAIL abort_result_kept: got %0d/%0d want %0d/%0d", bus.result, bus.result_id, last_res, last_id); end
            dones = 0;
            for (int n = 0; n < 4; n++) begin
                @(negedge clk);
                if (bus.done === 1'b1) dones++;
            end
            total++; if (dones != 0) begin bad++; $display("FAIL abort_no_done: got %0d want 0", dones); end
            rr_start = (exp_id + 1) % 4;
            exp_id = pick(4'b1111, rr_start);
            req_r = 4'b1111;
            observe_window(lat, g0, gs, iok, dc, res, rid);
            req_r = 4'b0000;
            total++; if (g0 !== (4'b0001 << exp_id) || rid !== 2'(exp_id) || res !== 10'd512) begin
                bad++; $display("FAIL abort_rr_advance: grant=%b id=%0d result=%0d want id %0d/512", g0, rid, res, exp_id); end
            rr_start = (exp_id + 1) % 4; last_res = 512; last_id = exp_id;
            @(negedge clk);
        end
`else
        steps = 0;
        for (int n = 1; n <= 700; n++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin steps = n; break; end
        end
        total++; if (steps != 462) begin bad++; $display("FAIL noabort_completes: got %0d want 462", steps); end
        total++; if (bus.result !== 10'd512 || bus.result_id !== 2'(exp_id)) begin
            bad++; $display("FAIL noabort_result: got %0d/%0d want 512/%0d", bus.result, bus.result_id, exp_id); end
        rr_start = (exp_id + 1) % 4; last_res = 512; last_id = exp_id;
        @(negedge clk);
        dones = 0;
`endif
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_alternating();
        test_wrap();
        test_random();
        test_back_to_back();
        test_reset_mid_run();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bitstream_sched.md
BITSTREAM_SCHED -- requirements
Module: bitstream_sched

Interface
REQ-001 The block SHALL have the parameter NREQ, default 4, giving the number of requesters (2..8).
REQ-002 The block SHALL have the parameter LEN_W, default 9, giving a window of 2**LEN_W cycles (one 512-bit bitstream period).
REQ-003 The block SHALL have port clk  input  1  the single clock; all state is updated on its rising edge.
REQ-004 The block SHALL have port n_rst  input  1  the reset, asynchronous and active-low.
REQ-005 The block SHALL have port req  input  NREQ  per-requester level request for one evaluation window.
REQ-006 The block SHALL have port gen_bit  input  1  the bitstream bit from the shared datapath for the current gen_idx, valid in the same cycle.
REQ-007 The block SHALL have port gen_en  output  1  high while the shared datapath is being stepped.
REQ-008 The block SHALL have port gen_idx  output  LEN_W  the stream position driven to the shared constant generators.
REQ-009 The block SHALL have port grant  output  NREQ  one-hot owner of the shared datapath; all zero when idle.
REQ-010 The block SHALL have port done  output  1  a one-cycle pulse when a window completes.
REQ-011 The block SHALL have port result  output  LEN_W+1  the count of ones over the completed window (0..2**LEN_W).
REQ-012 The block SHALL have port result_id  output  $clog2(NREQ)  the requester that owns result.

Function
REQ-013 The FSM SHALL have the states IDLE, RUN and DONE.
REQ-014 In IDLE with req nonzero, the FSM SHALL move to RUN on the next edge, latching a one-hot grant for the round-robin winner.
REQ-015 The round-robin search SHALL start at the index one above the last completed owner, wrap from NREQ-1 to 0, and start at 0 after reset.
REQ-016 In RUN, gen_en SHALL be 1 and gen_idx SHALL start at 0 and increment by 1 each cycle.
REQ-017 In RUN, the accumulator SHALL add gen_bit each cycle; the accumulator is LEN_W+1 bits wide and cannot overflow.
REQ-018 After the cycle with gen_idx = 2**LEN_W-1, the FSM SHALL move to DONE; gen_idx SHALL return to 0 and SHALL NOT wrap back into RUN.
REQ-019 In DONE, for exactly one cycle, done SHALL be 1, grant SHALL be 0 and gen_en SHALL be 0.
REQ-020 In DONE, result SHALL show the final count including the last bit, and result_id SHALL show the owner.
REQ-021 The rr pointer SHALL be updated in DONE, and the FSM SHALL then move to IDLE.
REQ-022 From req sampled high in IDLE to the done pulse SHALL be exactly 2**LEN_W+1 cycles; back-to-back windows SHALL be separated by one IDLE cycle.
REQ-023 result and result_id SHALL hold until the next DONE.
REQ-024 The accumulator SHALL clear on entry to RUN.
REQ-025 req changes during RUN SHALL be ignored, except as defined by the macro in REQ-029.
REQ-026 Requests that arrive together SHALL be resolved by the round-robin order only.

Reset
REQ-027 When n_rst is low, the block SHALL asynchronously force state = IDLE and gen_en = 0, gen_idx = 0, grant = 0, done = 0, result = 0, result_id = 0.
REQ-028 Reset asserted mid-RUN SHALL abandon the window with no done pulse; the first grant after reset SHALL go to the lowest-index requesting input.

Configuration
REQ-029 With `BSCHED_ABORT_EN defined: if the owner's req drops during RUN, the FSM SHALL return to IDLE on the next edge with grant = 0, no done pulse, result unchanged and the rr pointer advanced past the owner.
REQ-030 With `BSCHED_ABORT_EN undefined, a granted window SHALL always run to completion.

Verification
REQ-031 Bench: gen_bit tied 1, req = 4'b0001 -> grant = 4'b0001 for 512 cycles, then done with result = 512 and result_id = 0.
REQ-032 Bench: gen_bit = gen_idx[0], req = 4'b0010 -> result = 256, result_id = 1, done exactly 513 cycles after req is sampled.
REQ-033 Bench: req = 4'b0101 held from reset -> windows owned by id 0, then id 2, then id 0, each separated by one IDLE cycle.
REQ-034 Bench: after an id 3 window with req = 4'b1001 -> the next grant goes to id 0 (wrap).
REQ-035 Bench: n_rst pulsed low at gen_idx = 100 -> all outputs 0 immediately, no done pulse, and the next grant goes to the lowest requesting id.
REQ-036 Bench: with BSCHED_ABORT_EN, req dropped at gen_idx = 50 -> IDLE next cycle, no done, result keeps its previous value; without the macro, the window completes.
